quad_encoder_reader: RTL and testbench

//  Avalon-MM slave that reads the incremental quadrature encoder (A/B/Index) mounted on the

---
 rtl/quad_encoder_reader.sv | 239 +++++++++++++++++++++++
 tb/tb_quad_encoder_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_reader.sv
// Avalon-MM quadrature encoder reader: x4 decode into a signed 32-bit position, illegal-transition
// and index stickies, windowed speed. Optional macro QENC_INDEX_CLEAR_EN: index edge zeroes POSITION.
module quad_encoder_reader #(
    parameter int unsigned FILT_LEN    = 3,
    parameter logic [31:0] WIN_DEFAULT = 32'd50000
) (
    input  logic        rsi_MRST_reset,
    input  logic        csi_MCLK_clk,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_index
);

    localparam logic [3:0] FILT_TERM = 4'(FILT_LEN - 1);

    localparam logic [2:0] ADDR_POS    = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_SPEED  = 3'd3;
    localparam logic [2:0] ADDR_WINDOW = 3'd4;

    // Channel order in the input path: bit0 = B, bit1 = A, bit2 = index.
    logic [2:0]  w_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_filt;
    logic [3:0]  r_fcnt [3];

    logic        r_primed;
    logic [1:0]  r_prev_ab;
    logic        r_prev_idx;

    logic        r_ctrl_en;
    logic        r_ctrl_inv;
    logic        r_dir_fwd;
    logic        r_illegal;
    logic        r_idx_seen;

    logic [31:0] r_position;
    logic [31:0] r_window;
    logic [31:0] r_win_cnt;
    logic [31:0] r_win_acc;
    logic [31:0] r_speed;
    logic [31:0] r_readdata;

    logic        w_fwd;
    logic        w_rev;
    logic        w_jump;
    logic        w_step;
    logic        w_step_fwd;
    logic [31:0] w_step_val;
    logic [31:0] w_step_ext;
    logic        w_illegal;
    logic        w_index_rise;
    logic        w_wr_pos;
    logic        w_wr_ctrl;
    logic        w_wr_win;
    logic        w_clear;
    logic [31:0] w_pos_merged;
    logic [31:0] w_win_merged;

    assign w_raw                = {enc_index, enc_a, enc_b};
    assign avs_ctrl_waitrequest = 1'b0;
    assign avs_ctrl_readdata    = r_readdata;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Two-flop synchroniser for the asynchronous encoder pins.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values in parallel.
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level filter: a new level is accepted after FILT_LEN consecutive samples that disagree.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_filt <= '0;
            // NOTE: the counter array is only three small registers, so it is reset like any flop.
            for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FILT_TERM) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_primed   <= 1'b0;
            r_prev_ab  <= '0;
            r_prev_idx <= 1'b0;
        end else begin
            r_primed   <= 1'b1;
            r_prev_ab  <= r_filt[1:0];
            r_prev_idx <= r_filt[2];
        end
    end

    always_comb begin
        // NOTE: defaults first keep this block free of inferred latches.
        w_fwd  = 1'b0;
        w_rev  = 1'b0;
        w_jump = 1'b0;
        if (r_primed) begin
            case ({r_prev_ab, r_filt[1:0]})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_fwd  = 1'b1;
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: w_rev  = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_jump = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_step       = r_ctrl_en & (w_fwd | w_rev);
    assign w_step_fwd   = w_fwd ^ r_ctrl_inv;
    assign w_step_val   = w_step_fwd ? 32'd1 : 32'hFFFF_FFFF;
    assign w_step_ext   = w_step ? w_step_val : 32'd0;
    assign w_illegal    = r_ctrl_en & w_jump;
    assign w_index_rise = r_primed & r_filt[2] & ~r_prev_idx;

    assign w_wr_pos     = avs_ctrl_write & (avs_ctrl_address == ADDR_POS);
    assign w_wr_ctrl    = avs_ctrl_write & (avs_ctrl_address == ADDR_CTRL);
    assign w_wr_win     = avs_ctrl_write & (avs_ctrl_address == ADDR_WINDOW);
    assign w_clear      = w_wr_ctrl & avs_ctrl_writedata[2];
    assign w_pos_merged = byte_merge(r_position, avs_ctrl_writedata, avs_ctrl_byteenable);
    assign w_win_merged = byte_merge(r_window, avs_ctrl_writedata, avs_ctrl_byteenable);

    // Host write wins over a same-cycle step or index clear.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_position <= '0;
        end else if (w_wr_pos) begin
            r_position <= w_pos_merged;
`ifdef QENC_INDEX_CLEAR_EN
        end else if (w_index_rise && r_ctrl_en) begin
            r_position <= '0;
`endif
        end else if (w_step) begin
            r_position <= r_position + w_step_val;
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_ctrl_en  <= 1'b0;
            r_ctrl_inv <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ctrl_en  <= avs_ctrl_writedata[0];
            r_ctrl_inv <= avs_ctrl_writedata[1];
        end
    end

    // A clear request beats a sticky set arriving in the same cycle.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_dir_fwd  <= 1'b0;
            r_illegal  <= 1'b0;
            r_idx_seen <= 1'b0;
        end else begin
            if (w_step) r_dir_fwd <= w_step_fwd;
            if (w_clear)        r_illegal <= 1'b0;
            else if (w_illegal) r_illegal <= 1'b1;
            if (w_clear)           r_idx_seen <= 1'b0;
            else if (w_index_rise) r_idx_seen <= 1'b1;
        end
    end

    // Speed window: SPEED captures the net step count of each completed window.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_window  <= WIN_DEFAULT;
            r_win_cnt <= '0;
            r_win_acc <= '0;
            r_speed   <= '0;
        end else if (w_wr_win) begin
            r_window  <= w_win_merged;
            r_win_cnt <= '0;
            r_win_acc <= '0;
        end else if (r_ctrl_en) begin
            if (r_window == 32'd0) begin
                r_win_cnt <= '0;
                r_win_acc <= '0;
            end else if (r_win_cnt == r_window - 32'd1) begin
                r_speed   <= r_win_acc + w_step_ext;
                r_win_acc <= '0;
                r_win_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 32'd1;
                r_win_acc <= r_win_acc + w_step_ext;
            end
        end
    end

    // Registered read port; a simultaneous write suppresses the read.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_readdata <= '0;
        end else if (avs_ctrl_read && !avs_ctrl_write) begin
            case (avs_ctrl_address)
                ADDR_POS:    r_readdata <= r_position;
                ADDR_CTRL:   r_readdata <= {30'd0, r_ctrl_inv, r_ctrl_en};
                ADDR_STATUS: r_readdata <= {29'd0, r_idx_seen, r_illegal, r_dir_fwd};
                ADDR_SPEED:  r_readdata <= r_speed;
                ADDR_WINDOW: r_readdata <= r_window;
                default:     r_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Self-checking bench for quad_encoder_reader: register table plus encoder motion sequences,
// with read results checked through an expected-value queue.
module tb_quad_encoder_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  be = 4'hF;
    logic [2:0]  addr = '0;
    logic        wr = 1'b0;
    logic        rd_s = 1'b0;
    logic        waitreq;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        enc_index = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int g       = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        string       name;
    } vec_t;
    vec_t vecs[$];

    quad_encoder_reader dut (
        .rsi_MRST_reset      (rst),
        .csi_MCLK_clk        (clk),
        .avs_ctrl_writedata  (wdata),
        .avs_ctrl_readdata   (rdata),
        .avs_ctrl_byteenable (be),
        .avs_ctrl_address    (addr),
        .avs_ctrl_write      (wr),
        .avs_ctrl_read       (rd_s),
        .avs_ctrl_waitrequest(waitreq),
        .enc_a               (enc_a),
        .enc_b               (enc_b),
        .enc_index           (enc_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        sb_q.push_back('{name: nm, exp: e});
        addr = a;
        rd_s = 1'b1;
        wait_clk(1);
        rd_s = 1'b0;
        x = sb_q.pop_front();
        check(x.name, rdata, x.exp);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        addr  = a;
        wdata = d;
        be    = b;
        wr    = 1'b1;
        wait_clk(1);
        wr    = 1'b0;
        be    = 4'hF;
    endtask

    function automatic logic [1:0] gray(input int k);
        case (k)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // dir: +1 forward, -1 reverse, +2 double jump; hold gap clocks afterwards.
    task automatic move(input int dir, input int gap);
        g = (g + dir + 4) % 4;
        {enc_a, enc_b} = gray(g);
        wait_clk(gap);
    endtask

    logic [31:0] exp_pos6;
    logic [31:0] held;

    initial begin
        vecs.push_back('{1'b0, 3'd4, 32'd50000,     4'hF, "rst_window"});
        vecs.push_back('{1'b0, 3'd0, 32'd0,         4'hF, "rst_position"});
        vecs.push_back('{1'b0, 3'd1, 32'd0,         4'hF, "rst_control"});
        vecs.push_back('{1'b0, 3'd2, 32'd0,         4'hF, "rst_status"});
        vecs.push_back('{1'b0, 3'd3, 32'd0,         4'hF, "rst_speed"});
        vecs.push_back('{1'b0, 3'd5, 32'd0,         4'hF, "rst_addr5"});
        vecs.push_back('{1'b0, 3'd7, 32'd0,         4'hF, "rst_addr7"});
        vecs.push_back('{1'b1, 3'd0, 32'h11223344,  4'hF, ""});
        vecs.push_back('{1'b0, 3'd0, 32'h11223344,  4'hF, "pos_full_write"});
        vecs.push_back('{1'b1, 3'd0, 32'hAABBCCDD,  4'h5, ""});
        vecs.push_back('{1'b0, 3'd0, 32'h11BB33DD,  4'hF, "pos_byte_enable"});
        vecs.push_back('{1'b1, 3'd4, 32'h0000FFFF,  4'h3, ""});
        vecs.push_back('{1'b0, 3'd4, 32'h0000FFFF,  4'hF, "win_low_bytes"});
        vecs.push_back('{1'b1, 3'd4, 32'h12345678,  4'h8, ""});
        vecs.push_back('{1'b0, 3'd4, 32'h1200FFFF,  4'hF, "win_top_byte"});
        vecs.push_back('{1'b1, 3'd6, 32'hFFFFFFFF,  4'hF, ""});
        vecs.push_back('{1'b0, 3'd6, 32'd0,         4'hF, "addr6_ignored"});
        vecs.push_back('{1'b1, 3'd1, 32'hFFFFFFFF,  4'hF, ""});
        vecs.push_back('{1'b0, 3'd1, 32'd3,         4'hF, "ctrl_readback"});
        vecs.push_back('{1'b1, 3'd1, 32'd0,         4'hF, ""});
        vecs.push_back('{1'b0, 3'd1, 32'd0,         4'hF, "ctrl_cleared"});
        vecs.push_back('{1'b1, 3'd0, 32'd0,         4'hF, ""});
        vecs.push_back('{1'b1, 3'd4, 32'd50000,     4'hF, ""});
        vecs.push_back('{1'b0, 3'd3, 32'd0,         4'hF, "speed_idle"});

        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("waitrequest_low", {31'd0, waitreq}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) wr_reg(vecs[i].addr, vecs[i].data, vecs[i].be);
            else               rd(vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // Forward then reverse counting.
        wr_reg(3'd1, 32'd1, 4'hF);
        for (int i = 0; i < 8; i++) move(1, 20);
        rd(3'd0, 32'd8, "fwd8_position");
        rd(3'd2, 32'd1, "fwd8_status_dir");
        for (int i = 0; i < 3; i++) move(-1, 20);
        rd(3'd0, 32'd5, "rev3_position");
        rd(3'd2, 32'd0, "rev3_status_dir");

        // Wrap and direction inversion.
        wr_reg(3'd0, 32'h7FFFFFFF, 4'hF);
        move(1, 20);
        rd(3'd0, 32'h80000000, "wrap_positive");
        wr_reg(3'd1, 32'd3, 4'hF);
        move(1, 20);
        rd(3'd0, 32'h7FFFFFFF, "invert_step");

        // Illegal double transition and sticky clear.
        move(2, 20);
        rd(3'd0, 32'h7FFFFFFF, "illegal_no_count");
        rd(3'd2, 32'd2, "illegal_sticky");
        wr_reg(3'd1, 32'd5, 4'hF);
        rd(3'd2, 32'd0, "illegal_cleared");
        rd(3'd1, 32'd1, "clear_self_clears");

        // A glitch shorter than the filter length must not count.
        wr_reg(3'd0, 32'd0, 4'hF);
        enc_a = ~enc_a;
        wait_clk(2);
        enc_a = ~enc_a;
        wait_clk(20);
        rd(3'd0, 32'd0, "glitch_rejected");
        rd(3'd2, 32'd0, "glitch_no_illegal");

        // Speed over a 1000-clock window.
        wr_reg(3'd4, 32'd1000, 4'hF);
        for (int i = 0; i < 25; i++) move(1, 100);
        rd(3'd3, 32'd10, "speed_window");
        rd(3'd0, 32'd25, "speed_position");
        wr_reg(3'd4, 32'd0, 4'hF);
        for (int i = 0; i < 5; i++) move(1, 100);
        rd(3'd3, 32'd10, "speed_held_win0");
        rd(3'd0, 32'd30, "win0_position");

        // Index pulse.
        wr_reg(3'd0, 32'd500, 4'hF);
        enc_index = 1'b1;
        wait_clk(10);
        enc_index = 1'b0;
        wait_clk(20);
`ifdef QENC_INDEX_CLEAR_EN
        exp_pos6 = 32'd0;
`else
        exp_pos6 = 32'd500;
`endif
        rd(3'd2, 32'd5, "index_sticky");
        rd(3'd0, exp_pos6, "index_position");

        // Read and write together: write lands, readdata holds.
        held = exp_pos6;
        addr  = 3'd4;
        wdata = 32'd777;
        be    = 4'hF;
        wr    = 1'b1;
        rd_s  = 1'b1;
        wait_clk(1);
        wr    = 1'b0;
        rd_s  = 1'b0;
        check("rw_readdata_holds", rdata, held);
        rd(3'd4, 32'd777, "rw_write_done");

        // Reset in the middle of operation.
        move(1, 3);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        rd(3'd0, 32'd0, "midrst_position");
        rd(3'd1, 32'd0, "midrst_control");
        rd(3'd2, 32'd0, "midrst_status");
        rd(3'd3, 32'd0, "midrst_speed");
        rd(3'd4, 32'd50000, "midrst_window");
        wait_clk(20);
        rd(3'd2, 32'd0, "midrst_settle_status");
        wr_reg(3'd1, 32'd1, 4'hF);
        move(1, 20);
        rd(3'd0, 32'd1, "midrst_count_resumes");
        check("waitrequest_end", {31'd0, waitreq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
